// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared state encoding and mode constants for the pulse train generator
package pulse_gen_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic MODE_FREE  = 1'b0;
    localparam logic MODE_BURST = 1'b1;
endpackage

// File: rtl/period_counter.sv
// period_counter: 0..period_m1 cycle counter with reload-to-zero and a last-cycle flag
module period_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] period_m1,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nx,
    output logic             last
);
    assign last   = cnt == period_m1;
    assign cnt_nx = load ? '0 : en ? cnt + 1'b1 : cnt;
    // Count register; load wins so a wrap or an idle cycle always restarts at zero
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= cnt_nx;
endmodule

// File: rtl/pulse_train_generator.sv
// pulse_train_generator: programmable period/high-time pulse source, free-running or counted burst
module pulse_train_generator
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               mode,
    input  logic               start,
    input  logic [CNT_W-1:0]   period_m1,
    input  logic [CNT_W-1:0]   width,
    input  logic [BURST_W-1:0] burst_len,
    output logic               out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);
    state_t             state, state_nx;
    logic [CNT_W-1:0]   p_s, h_s, h_nx, cnt, cnt_nx;
    logic [BURST_W-1:0] n_s, pc_inc, pc_nx;
    logic               mode_s, last, go, zero, wrap, fin, reload;

    period_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (state != RUN || last),
        .en        (state == RUN),
        .period_m1 (p_s),
        .cnt       (cnt),
        .cnt_nx    (cnt_nx),
        .last      (last)
    );

    assign go     = state == IDLE && (mode == MODE_FREE ? en : start && burst_len != '0);
    assign zero   = state == IDLE && mode == MODE_BURST && start && burst_len == '0;
    assign wrap   = state == RUN && last;
    assign pc_inc = pulse_cnt + 1'b1;
    assign fin    = wrap && (mode_s == MODE_FREE ? !en : pc_inc == n_s);
    assign reload = go || wrap;
    assign h_nx   = reload ? width : h_s;
    assign pc_nx  = go ? '0 : (wrap && mode_s == MODE_BURST) ? pc_inc : pulse_cnt;

    // Next state: start conditions from IDLE, end-of-period exits from RUN, DONE lasts one cycle
    always_comb
        state_nx = go ? RUN :
                   zero ? DONE :
                   fin ? (mode_s == MODE_FREE ? IDLE : DONE) :
                   state == DONE ? IDLE : state;

    // State, shadowed config, burst count and registered outputs; config only lands at a wrap
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            p_s       <= '0;
            h_s       <= '0;
            n_s       <= '0;
            mode_s    <= MODE_FREE;
            pulse_cnt <= '0;
            out       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            if (reload) begin
                p_s <= period_m1;
                h_s <= width;
            end
            if (go) begin
                n_s    <= burst_len;
                mode_s <= mode;
            end
            pulse_cnt <= pc_nx;
            out       <= state_nx == RUN && cnt_nx < h_nx;
            busy      <= state_nx == RUN;
            done      <= state_nx == DONE;
        end
endmodule

// File: tb/tb_pulse_train_generator.sv
// tb_pulse_train_generator: directed checks of free-run, burst, boundaries, shadowing and async reset
module tb_pulse_train_generator;
    logic       clk = 1'b0;
    logic       reset, en, mode, start;
    logic [7:0] period_m1, width, burst_len;
    logic       out, busy, done;
    logic [7:0] pulse_cnt;
    int         checks = 0;
    int         errors = 0;

    pulse_train_generator #(.CNT_W(8), .BURST_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .start     (start),
        .period_m1 (period_m1),
        .width     (width),
        .burst_len (burst_len),
        .out       (out),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0;
        period_m1 = 8'd0; width = 8'd0; burst_len = 8'd0;
        #12;
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pcnt", pulse_cnt, 0);
        reset = 1'b0;

        // free run P=5 H=1
        period_m1 = 8'd4; width = 8'd1; en = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("free_out", out, (i % 5 == 0));
            check("free_busy", busy, 1);
            check("free_pcnt", pulse_cnt, 0);
            tick();
        end
        en = 1'b0;
        check("free_cnt0_again", out, 1);
        wait_idle("free_stop");
        check("free_stop_out", out, 0);

        // burst P=4 H=2 N=3
        mode = 1'b1; period_m1 = 8'd3; width = 8'd2; burst_len = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("burst_out", out, (i % 4 < 2));
            check("burst_busy", busy, 1);
            check("burst_pcnt", pulse_cnt, i / 4);
            check("burst_done_lo", done, 0);
            tick();
        end
        check("burst_done", done, 1);
        check("burst_done_busy", busy, 0);
        check("burst_done_out", out, 0);
        check("burst_final_pcnt", pulse_cnt, 3);
        tick();
        check("burst_done_strobe", done, 0);
        check("burst_idle_busy", busy, 0);
        check("burst_hold_pcnt", pulse_cnt, 3);

        // free run P=8 H=3, drop en while cnt=2
        mode = 1'b0; period_m1 = 8'd7; width = 8'd3; en = 1'b1;
        tick();
        tick();
        tick();
        check("stop_cnt2_out", out, 1);
        en = 1'b0;
        for (int c = 3; c < 8; c++) begin
            tick();
            check("stop_tail_busy", busy, 1);
            check("stop_tail_out", out, 0);
        end
        tick();
        check("stop_idle", busy, 0);

        // width=0: never high
        period_m1 = 8'd2; width = 8'd0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("w0_out", out, 0);
            check("w0_busy", busy, 1);
        end
        en = 1'b0;
        wait_idle("w0_stop");

        // width=9 with P=5: constant high
        period_m1 = 8'd4; width = 8'd9; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("wbig_out", out, 1);
        end
        en = 1'b0;
        wait_idle("wbig_stop");
        check("wbig_idle_out", out, 0);

        // burst N=0: immediate done, no pulses
        mode = 1'b1; burst_len = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("n0_done", done, 1);
        check("n0_busy", busy, 0);
        check("n0_out", out, 0);
        tick();
        check("n0_done_clr", done, 0);
        check("n0_out2", out, 0);

        // period change 4->1 mid-period takes effect at the next wrap
        mode = 1'b0; period_m1 = 8'd4; width = 8'd1; en = 1'b1;
        tick();
        tick();
        check("shadow_cnt1_out", out, 0);
        period_m1 = 8'd1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("shadow_out", out, (i == 3 || i == 5));
        end
        en = 1'b0;
        wait_idle("shadow_stop");

        // async reset mid-burst at cnt=2, then a fresh burst
        mode = 1'b1; period_m1 = 8'd3; width = 8'd3; burst_len = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("pre_rst_pcnt", pulse_cnt, 1);
        check("pre_rst_out", out, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_out", out, 0);
        check("arst_busy", busy, 0);
        check("arst_pcnt", pulse_cnt, 0);
        tick();
        check("arst_no_done", done, 0);
        #2 reset = 1'b0;
        period_m1 = 8'd1; width = 8'd1; burst_len = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("post_out", out, 1);
        check("post_busy", busy, 1);
        tick();
        check("post_out2", out, 0);
        tick();
        check("post_done", done, 1);
        check("post_pcnt", pulse_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
